// File: rtl/draw_sprites_pkg.sv
// Shared types, defaults and address helper for the sprite compositor.
// Imported by vga_if users, sprite_hit and draw_sprites.
package draw_sprites_pkg;

  localparam int DEF_SPR_W = 48;
  localparam int DEF_SPR_H = 48;
  localparam int DEF_ADDR_W = 12;
  localparam logic [11:0] DEF_KEY_RGB = 12'h0F0;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic        en;
    logic        mirror;
  } spr_pos_t;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;

  // Sprite ROM address for the default sprite width.
  function automatic logic [DEF_ADDR_W-1:0] spr_addr(
    input logic [12:0] row,
    input logic [12:0] col,
    input logic        mirror
  );
    logic [12:0] colm;
    logic [25:0] a;
    colm = mirror ? 13'(DEF_SPR_W - 1) - col : col;
    a = 26'(row) * 26'(DEF_SPR_W) + 26'(colm);
    return a[DEF_ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/vga_if.sv
// VGA pixel-stream bundle between drawing stages.
// Driver uses modport out, consumer uses modport in.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in (
    input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
  );
  modport out (
    output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
  );
endinterface

// File: rtl/sprite_hit.sv
// One sprite channel of stage 1: hit test, mirror and ROM address.
// Offsets are 13-bit signed so far-right positions never wrap.
module sprite_hit
  import draw_sprites_pkg::*;
#(
  parameter int W  = DEF_SPR_W,
  parameter int H  = DEF_SPR_H,
  parameter int AW = DEF_ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [10:0]   hcount,
  input  logic [10:0]   vcount,
  input  logic          hblnk,
  input  logic          vblnk,
  input  spr_pos_t      pos,
  output logic          hit,
  output logic [AW-1:0] addr
);

  logic [12:0] col;
  logic [12:0] row;
  logic        in_col;
  logic        in_row;
  logic        hit_c;

  assign col = {2'b00, hcount} - {1'b0, pos.x};
  assign row = {2'b00, vcount} - {1'b0, pos.y};

  assign in_col = !col[12] && (col < 13'(W));
  assign in_row = !row[12] && (row < 13'(H));

  assign hit_c = pos.en & in_col & in_row & !hblnk & !vblnk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit  <= 1'b0;
      addr <= '0;
    end else begin
      hit  <= hit_c;
      addr <= hit_c ? AW'(spr_addr(row, col, pos.mirror)) : '0;
    end
  end

endmodule

// File: rtl/draw_sprites.sv
// Multi-channel sprite compositor with frame-latched positions,
// colour-key transparency and per-sprite horizontal mirroring.
module draw_sprites
  import draw_sprites_pkg::*;
#(
  parameter int          N_SPR   = 2,
  parameter int          SPR_W   = DEF_SPR_W,
  parameter int          SPR_H   = DEF_SPR_H,
  parameter int          ADDR_W  = DEF_ADDR_W,
  parameter int          ROM_LAT = 1,
  parameter logic [11:0] KEY_RGB = DEF_KEY_RGB
) (
  input  logic                          clk,
  input  logic                          rst,
  vga_if.in                             vga_in,
  vga_if.out                            vga_out,
  input  logic [N_SPR-1:0][11:0]        spr_x,
  input  logic [N_SPR-1:0][11:0]        spr_y,
  input  logic [N_SPR-1:0]              spr_en,
  input  logic [N_SPR-1:0]              spr_mirror,
  output logic [N_SPR-1:0][ADDR_W-1:0]  pixel_addr,
  input  logic [N_SPR-1:0][11:0]        rgb_pixel
);

  localparam int LAT = ROM_LAT + 2;

  logic                   vblnk_q;
  spr_pos_t [N_SPR-1:0]   shadow;
  vga_t                   cur;
  vga_t                   dly [LAT-1];
  vga_t                   bg;
  vga_t                   nxt;
  vga_t                   out_q;
  logic [N_SPR-1:0]       hit;
  logic [N_SPR-1:0]       hit_d [ROM_LAT];

  assign cur = {vga_in.hcount, vga_in.vcount,
                vga_in.hsync, vga_in.vsync,
                vga_in.hblnk, vga_in.vblnk,
                vga_in.rgb};

  // Positions only change at the vblnk rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vblnk_q <= 1'b0;
      shadow  <= '0;
    end else begin
      vblnk_q <= vga_in.vblnk;
      if (vga_in.vblnk && !vblnk_q) begin
        for (int i = 0; i < N_SPR; i++) begin
          shadow[i] <= '{x: spr_x[i], y: spr_y[i],
                         en: spr_en[i], mirror: spr_mirror[i]};
        end
      end
    end
  end

  for (genvar g = 0; g < N_SPR; g++) begin : g_hit
    sprite_hit #(
      .W  (SPR_W),
      .H  (SPR_H),
      .AW (ADDR_W)
    ) u_hit (
      .clk    (clk),
      .rst_n  (rst),
      .hcount (vga_in.hcount),
      .vcount (vga_in.vcount),
      .hblnk  (vga_in.hblnk),
      .vblnk  (vga_in.vblnk),
      .pos    (shadow[g]),
      .hit    (hit[g]),
      .addr   (pixel_addr[g])
    );
  end

  assign bg = dly[LAT-2];

  always_comb begin
    nxt = bg;
    if (!(bg.hblnk || bg.vblnk)) begin
      for (int i = N_SPR - 1; i >= 0; i--) begin
        if (hit_d[ROM_LAT-1][i] && rgb_pixel[i] != KEY_RGB) begin
          nxt.rgb = rgb_pixel[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < LAT - 1; k++) dly[k] <= '0;
      for (int k = 0; k < ROM_LAT; k++) hit_d[k] <= '0;
      out_q <= '0;
    end else begin
      dly[0] <= cur;
      for (int k = 1; k < LAT - 1; k++) dly[k] <= dly[k-1];
      hit_d[0] <= hit;
      for (int k = 1; k < ROM_LAT; k++) hit_d[k] <= hit_d[k-1];
      out_q <= nxt;
    end
  end

  assign vga_out.hcount = out_q.hcount;
  assign vga_out.vcount = out_q.vcount;
  assign vga_out.hsync  = out_q.hsync;
  assign vga_out.vsync  = out_q.vsync;
  assign vga_out.hblnk  = out_q.hblnk;
  assign vga_out.vblnk  = out_q.vblnk;
  assign vga_out.rgb    = out_q.rgb;

endmodule

// File: tb/tb_draw_sprites.sv
// Directed bench for draw_sprites with a 1-cycle ROM model.
// Each task drives one scenario and checks outputs inline.
module tb_draw_sprites;

  localparam int          N   = 2;
  localparam int          AW  = 12;
  localparam int          LAT = 3;
  localparam logic [11:0] BG  = 12'h123;
  localparam logic [11:0] RED = 12'hF00;
  localparam logic [11:0] BLU = 12'h00F;
  localparam logic [11:0] KEY = 12'h0F0;

  logic clk = 1'b0;
  logic rst = 1'b0;

  vga_if vi();
  vga_if vo();

  logic [N-1:0][11:0]   spr_x = '0;
  logic [N-1:0][11:0]   spr_y = '0;
  logic [N-1:0]         spr_en = '0;
  logic [N-1:0]         spr_mirror = '0;
  logic [N-1:0][AW-1:0] pixel_addr;
  logic [N-1:0][11:0]   rgb_pixel = '0;

  int checks = 0;
  int failures = 0;
  int rom_mode = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rgb_pixel[0] <= (rom_mode == 1 && pixel_addr[0] == '0) ? KEY : RED;
    rgb_pixel[1] <= BLU;
  end

  draw_sprites dut (
    .clk        (clk),
    .rst        (rst),
    .vga_in     (vi),
    .vga_out    (vo),
    .spr_x      (spr_x),
    .spr_y      (spr_y),
    .spr_en     (spr_en),
    .spr_mirror (spr_mirror),
    .pixel_addr (pixel_addr),
    .rgb_pixel  (rgb_pixel)
  );

  task automatic put(input int h, input int v,
                     input logic hb, input logic vb,
                     input logic hs, input logic vs);
    vi.hcount = 11'(h);
    vi.vcount = 11'(v);
    vi.hblnk  = hb;
    vi.vblnk  = vb;
    vi.hsync  = hs;
    vi.vsync  = vs;
    vi.rgb    = BG;
    @(posedge clk);
    #1;
  endtask

  task automatic vblank_pulse();
    repeat (3) put(0, 490, 1'b1, 1'b1, 1'b0, 1'b1);
    put(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_spr(input int i, input int x, input int y,
                         input logic en, input logic mir);
    spr_x[i]      = 12'(x);
    spr_y[i]      = 12'(y);
    spr_en[i]     = en;
    spr_mirror[i] = mir;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    vi.hcount = 11'd5; vi.vcount = 11'd7;
    vi.hsync = 1'b1; vi.vsync = 1'b1;
    vi.hblnk = 1'b0; vi.vblnk = 1'b0;
    vi.rgb = BG;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (vo.rgb !== 12'h000)
      $display("FAIL reset_rgb: got %h want 000", vo.rgb);
    checks++;
    if (vo.hsync !== 1'b0 || vo.vsync !== 1'b0)
      $display("FAIL reset_sync: got %b%b want 00", vo.hsync, vo.vsync);
    checks++;
    if (vo.hcount !== 11'd0)
      $display("FAIL reset_hcount: got %0d want 0", vo.hcount);
    checks++;
    if (pixel_addr !== '0)
      $display("FAIL reset_addr: got %h want 0", pixel_addr);
    failures += (vo.rgb !== 12'h000) + (vo.hsync !== 1'b0 || vo.vsync !== 1'b0)
              + (vo.hcount !== 11'd0) + (pixel_addr !== '0);
    rst = 1'b1;
  endtask

  task automatic test_single_sprite();
    int e;
    logic [11:0] exp_rgb;
    set_spr(0, 100, 50, 1'b1, 1'b0);
    set_spr(1, 0, 0, 1'b0, 1'b0);
    rom_mode = 0;
    repeat (3) put(110, 60, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (vo.rgb !== BG) begin
      failures++;
      $display("FAIL hidden_before_vblank: got %h want %h", vo.rgb, BG);
    end
    vblank_pulse();
    for (int j = 0; j < 56 + LAT - 1; j++) begin
      if (j < 56) put(96 + j, 50, 1'b0, 1'b0, 1'(j % 2), 1'b0);
      else put(0, 50, 1'b1, 1'b0, 1'b0, 1'b0);
      if (j >= LAT - 1) begin
        e = 96 + j - (LAT - 1);
        exp_rgb = (e >= 100 && e <= 147) ? RED : BG;
        checks++;
        if (vo.rgb !== exp_rgb) begin
          failures++;
          $display("FAIL line50_rgb h=%0d: got %h want %h", e, vo.rgb, exp_rgb);
        end
        checks++;
        if (vo.hcount !== 11'(e) || vo.hsync !== 1'(e % 2)) begin
          failures++;
          $display("FAIL line50_delay h=%0d: got %0d/%b", e, vo.hcount, vo.hsync);
        end
      end
    end
    put(100, 50, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pixel_addr[0] !== 12'd0) begin
      failures++;
      $display("FAIL addr_100_50: got %0d want 0", pixel_addr[0]);
    end
    put(147, 97, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pixel_addr[0] !== 12'd2303) begin
      failures++;
      $display("FAIL addr_147_97: got %0d want 2303", pixel_addr[0]);
    end
    repeat (2) put(147, 97, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (vo.rgb !== RED) begin
      failures++;
      $display("FAIL rgb_147_97: got %h want %h", vo.rgb, RED);
    end
    repeat (3) put(147, 98, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (vo.rgb !== BG || pixel_addr[0] !== 12'd0) begin
      failures++;
      $display("FAIL below_sprite: got %h/%0d want %h/0", vo.rgb, pixel_addr[0], BG);
    end
    repeat (3) put(120, 49, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (vo.rgb !== BG) begin
      failures++;
      $display("FAIL above_sprite: got %h want %h", vo.rgb, BG);
    end
  endtask

  task automatic test_mirror();
    set_spr(0, 100, 50, 1'b1, 1'b1);
    vblank_pulse();
    put(100, 50, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pixel_addr[0] !== 12'd47) begin
      failures++;
      $display("FAIL mirror_addr_100: got %0d want 47", pixel_addr[0]);
    end
    put(147, 50, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pixel_addr[0] !== 12'd0) begin
      failures++;
      $display("FAIL mirror_addr_147: got %0d want 0", pixel_addr[0]);
    end
    put(101, 51, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pixel_addr[0] !== 12'd94) begin
      failures++;
      $display("FAIL mirror_addr_101_51: got %0d want 94", pixel_addr[0]);
    end
  endtask

  task automatic test_transparency();
    set_spr(0, 200, 200, 1'b1, 1'b0);
    set_spr(1, 200, 200, 1'b1, 1'b0);
    rom_mode = 1;
    vblank_pulse();
    repeat (3) put(200, 200, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (vo.rgb !== BLU) begin
      failures++;
      $display("FAIL key_falls_through: got %h want %h", vo.rgb, BLU);
    end
    repeat (3) put(201, 200, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (vo.rgb !== RED) begin
      failures++;
      $display("FAIL priority_ch0: got %h want %h", vo.rgb, RED);
    end
    repeat (3) put(248, 200, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (vo.rgb !== BG) begin
      failures++;
      $display("FAIL right_of_both: got %h want %h", vo.rgb, BG);
    end
    rom_mode = 0;
  endtask

  task automatic test_frame_coherence();
    set_spr(0, 100, 50, 1'b1, 1'b0);
    set_spr(1, 0, 0, 1'b0, 1'b0);
    vblank_pulse();
    repeat (3) put(100, 60, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (vo.rgb !== RED) begin
      failures++;
      $display("FAIL coh_before: got %h want %h", vo.rgb, RED);
    end
    spr_x[0] = 12'd300;
    repeat (3) put(147, 97, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (vo.rgb !== RED) begin
      failures++;
      $display("FAIL coh_old_pos: got %h want %h", vo.rgb, RED);
    end
    repeat (3) put(300, 75, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (vo.rgb !== BG) begin
      failures++;
      $display("FAIL coh_no_tear: got %h want %h", vo.rgb, BG);
    end
    vblank_pulse();
    repeat (3) put(300, 75, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (vo.rgb !== RED) begin
      failures++;
      $display("FAIL coh_new_pos: got %h want %h", vo.rgb, RED);
    end
    repeat (3) put(120, 75, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (vo.rgb !== BG) begin
      failures++;
      $display("FAIL coh_old_gone: got %h want %h", vo.rgb, BG);
    end
  endtask

  task automatic test_edge_wrap();
    int e;
    logic [11:0] exp_rgb;
    set_spr(0, 620, 50, 1'b1, 1'b0);
    vblank_pulse();
    for (int j = 0; j < 28 + LAT - 1; j++) begin
      if (j < 28) put(616 + j, 60, 1'((616 + j) >= 640), 1'b0, 1'b0, 1'b0);
      else put(0, 61, 1'b0, 1'b0, 1'b0, 1'b0);
      if (j >= LAT - 1) begin
        e = 616 + j - (LAT - 1);
        exp_rgb = (e >= 620 && e <= 639) ? RED : BG;
        checks++;
        if (vo.rgb !== exp_rgb || vo.hblnk !== 1'(e >= 640)) begin
          failures++;
          $display("FAIL right_clip h=%0d: got %h/%b want %h", e, vo.rgb, vo.hblnk, exp_rgb);
        end
      end
    end
    set_spr(0, 4090, 50, 1'b1, 1'b0);
    vblank_pulse();
    for (int j = 0; j < 45 + LAT - 1; j++) begin
      if (j < 45) put(j, 60, 1'b0, 1'b0, 1'b0, 1'b0);
      else put(0, 61, 1'b1, 1'b0, 1'b0, 1'b0);
      if (j >= LAT - 1) begin
        e = j - (LAT - 1);
        checks++;
        if (vo.rgb !== BG) begin
          failures++;
          $display("FAIL wrap_4090 h=%0d: got %h want %h", e, vo.rgb, BG);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int e;
    set_spr(0, 100, 50, 1'b1, 1'b0);
    vblank_pulse();
    repeat (3) put(100, 50, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (vo.rgb !== RED || vo.hsync !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset: got %h/%b want %h/1", vo.rgb, vo.hsync, RED);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (vo.rgb !== 12'h000 || vo.hsync !== 1'b0 || vo.vsync !== 1'b0) begin
      failures++;
      $display("FAIL async_clear: got %h/%b%b want 000/00", vo.rgb, vo.hsync, vo.vsync);
    end
    checks++;
    if (pixel_addr !== '0 || vo.hcount !== 11'd0) begin
      failures++;
      $display("FAIL async_addr: got %h/%0d want 0/0", pixel_addr, vo.hcount);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int j = 0; j < 12 + LAT - 1; j++) begin
      if (j < 12) put(100 + j, 50, 1'b0, 1'b0, 1'(j % 2), 1'((j / 2) % 2));
      else put(0, 50, 1'b1, 1'b0, 1'b0, 1'b0);
      if (j >= LAT - 1) begin
        e = j - (LAT - 1);
        checks++;
        if (vo.hsync !== 1'(e % 2) || vo.vsync !== 1'((e / 2) % 2)) begin
          failures++;
          $display("FAIL post_reset_sync n=%0d: got %b%b", e, vo.hsync, vo.vsync);
        end
        checks++;
        if (vo.rgb !== BG) begin
          failures++;
          $display("FAIL post_reset_hidden n=%0d: got %h want %h", e, vo.rgb, BG);
        end
      end
    end
    vblank_pulse();
    repeat (3) put(100, 50, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (vo.rgb !== RED) begin
      failures++;
      $display("FAIL post_reset_shown: got %h want %h", vo.rgb, RED);
    end
  endtask

  initial begin
    test_reset();
    test_single_sprite();
    test_mirror();
    test_transparency();
    test_frame_coherence();
    test_edge_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/draw_sprites.md
Name: draw_sprites

Overview:
- Multi-channel sprite compositor on the vga_if pixel stream.
- Sits after draw_bg and replaces the single-rectangle draw_rect stage.
- Overlays N_SPR fixed-size sprites, each with its own ROM address and pixel return path, over the incoming background.
- Adds three features over the single-sprite stage: frame-coherent position latching, colour-key transparency, and per-sprite horizontal mirroring.

Parameters:
- N_SPR, 2, number of sprite channels; channel 0 has highest priority.
- SPR_W, 48, sprite width in pixels.
- SPR_H, 48, sprite height in pixels.
- ADDR_W, 12, ROM address width per channel; must satisfy 2**ADDR_W >= SPR_W*SPR_H.
- ROM_LAT, 1, fixed ROM read latency in clk cycles (1..3).
- KEY_RGB, 12'h0F0, transparent colour key.

Ports:
- clk  input  1  pixel clock
- rst  input  1  asynchronous reset, active-low
- vga_in  input  vga_if.in  hcount/vcount (11 b), hsync, vsync, hblnk, vblnk, rgb (12 b) from draw_bg
- vga_out  output  vga_if.out  same fields, delayed and composited
- spr_x  input  N_SPR x 12  sprite left edge (screen px)
- spr_y  input  N_SPR x 12  sprite top edge
- spr_en  input  N_SPR  sprite visible
- spr_mirror  input  N_SPR  1 = horizontally flipped
- pixel_addr  output  N_SPR x ADDR_W  per-channel ROM address
- rgb_pixel  input  N_SPR x 12  per-channel ROM data, valid ROM_LAT cycles after the address

Behaviour:
- Reset (rst=0, async): all vga_out fields, pixel_addr, shadow registers and pipeline registers = 0. After release, outputs are valid from the first full pipeline fill.
- Shadow latch:
  - spr_x/spr_y/spr_en/spr_mirror are copied to shadow registers on the cycle vga_in.vblnk rises (vblnk=1, registered vblnk=0).
  - All hit/address logic uses the shadows only, so position changes never tear mid-frame.
  - After reset the shadows stay 0 (all sprites disabled) until the first vblnk rise.
- Latency: LAT = ROM_LAT + 2 cycles, fixed, for every vga_out field. The sync/blank/count/background rgb are delayed through a LAT-deep shift register.
- Stage 1, per channel i, registered:
  - col = hcount - sx_i, row = vcount - sy_i, computed 13-bit signed.
  - hit_i = en_i & col in [0, SPR_W-1] & row in [0, SPR_H-1] & !hblnk & !vblnk.
  - Comparison is 13-bit, so sx near 4095 does not wrap into visible columns.
  - colm = mirror_i ? SPR_W-1-col : col.
  - pixel_addr_i = row*SPR_W + colm, truncated to ADDR_W. When !hit_i, pixel_addr_i holds 0.
- Stages 2..ROM_LAT+1: hit_i is delayed ROM_LAT cycles alongside the ROM read.
- Final stage (compose, registered):
  - Pick the lowest i with hit_i & rgb_pixel_i != KEY_RGB; output that rgb_pixel_i.
  - If no channel qualifies, output the delayed background rgb.
- Blanking: no sprite is drawn while the delayed hblnk|vblnk = 1; rgb passes through.
- Clipping:
  - A sprite partly off the right or bottom edge draws only its visible part.
  - A sprite fully outside the active area draws nothing.
- Simultaneous shadow update and active pixel is impossible, since the latch happens only at the vblnk rise.
- Reset mid-frame clears the pipeline. Output is sync-correct again after LAT cycles and positions take effect at the next vblnk rise.

Decomposition:
- Package draw_sprites_pkg holds:
  - SPR_W/SPR_H defaults, KEY_RGB default.
  - typedef spr_pos_t (12-bit x, y, en, mirror).
  - function spr_addr(row, col, mirror) returning ADDR_W bits.
- Sub-module sprite_hit: one channel of stage 1 (hit test, mirror, address), instantiated N_SPR times by generate.
- The delay line is a generic shift register inside the top.

Test Plan:
- Single sprite: spr_x=100, spr_y=50, en0=1, ROM returns 12'hF00; after vblnk rise → vga_out.rgb=F00 exactly at hcount 100..147, vcount 50..97, LAT cycles after input; background elsewhere; pixel_addr0 at (100,50)=0 and at (147,97)=2303.
- Mirror: spr_mirror0=1 at same position → pixel_addr0 at (100,50)=47 and at (147,50)=0.
- Transparency and priority:
  - Sprites 0 and 1 both at (200,200); ROM0 returns KEY_RGB for address 0 and F00 elsewhere; ROM1 returns 00F.
  - Output at (200,200) = 00F; output at (201,200) = F00.
- Frame coherence: change spr_x from 100 to 300 mid-frame at vcount=60 → rows 60..97 still drawn at x=100; new position visible only from the next frame.
- Edge/wrap:
  - spr_x=620 → only columns 620..639 drawn, nothing during hblnk.
  - spr_x=4090 → nothing drawn at hcount 0..42.
- Async reset: assert rst=0 mid-line → all outputs 0 immediately; release → hsync/vsync match the input delayed by LAT; sprites hidden until the next vblnk rise.
